marquee_tick_ctrl: RTL and testbench

User-control front end for the LED marquee. It synchronises and debounces the four board push-buttons and runs a RUN/PAUSE state machine. It also contains a programmable prescaler off the 125 MHz clock. Outputs are a one-cycle `step` strobe, a direction bit and a speed level, which feed the marquee's shift/pattern logic directly.

---
 rtl/marquee_tick_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_marquee_tick_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/marquee_tick_ctrl.sv
// marquee_tick_ctrl: push-button conditioning, RUN/PAUSE control and
// programmable step prescaler for the LED marquee.
module marquee_tick_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_250_000,
  parameter int unsigned BASE_DIV     = 31_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic       step,
  output logic       dir,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int unsigned NBTN = 4;
  localparam int unsigned DCW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned CW   = $clog2(BASE_DIV);
  localparam int unsigned PW   = CW + 1;

  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYC - 1);
  localparam logic [PW-1:0]  BASE_P  = PW'(BASE_DIV);

  localparam int unsigned B_SPEED = 0;
  localparam int unsigned B_DIR   = 1;
  localparam int unsigned B_PAUSE = 2;
  localparam int unsigned B_STEP  = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

  // Input conditioning
  logic [NBTN-1:0]          sync1_q;
  logic [NBTN-1:0]          sync2_q;
  logic [NBTN-1:0]          db_q;
  logic [NBTN-1:0]          db_d;
  logic [NBTN-1:0]          db_prev_q;
  logic [NBTN-1:0]          press_q;
  logic [NBTN-1:0]          press_d;
  logic [NBTN-1:0][DCW-1:0] dcnt_q;
  logic [NBTN-1:0][DCW-1:0] dcnt_d;

  // Control and prescaler
  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            step_q;
  logic            step_d;
  logic            dir_q;
  logic            dir_d;
  logic [1:0]      speed_q;
  logic [1:0]      speed_d;
  logic            paused_q;
  logic            paused_d;
  logic [PW-1:0]   per_c;
  logic            tc_c;

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce: accept a new level after it has been stable long enough
  always_comb begin
    db_d   = db_q;
    dcnt_d = dcnt_q;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DB_LAST) begin
        db_d[i]   = sync2_q[i];
        dcnt_d[i] = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + DCW'(1);
      end
    end
  end

  // Press pulse on each rising edge of the debounced level; releases are ignored
  always_comb begin
    press_d = db_q & ~db_prev_q;
  end

  // Debounce state, edge history and press pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q      <= '0;
      dcnt_q    <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
    end else begin
      db_q      <= db_d;
      dcnt_q    <= dcnt_d;
      db_prev_q <= db_q;
      press_q   <= press_d;
    end
  end

  // Current step period and terminal count
  always_comb begin
    per_c = BASE_P >> speed_q;
    tc_c  = (cnt_q == CW'(per_c - PW'(1)));
  end

  // RUN/PAUSE next state, prescaler, speed, direction and step strobe
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    speed_d  = speed_q;
    paused_d = paused_q;

    if (press_q[B_DIR]) begin
      dir_d = ~dir_q;
    end

    // A speed change restarts the period and swallows a coincident terminal count
    if (press_q[B_SPEED]) begin
      speed_d = speed_q + 2'd1;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      if (tc_c) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Single step is judged against the state before any pause toggle
    if (press_q[B_STEP] && (state_q == ST_PAUSE)) begin
      step_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (press_q[B_PAUSE]) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (press_q[B_PAUSE]) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    paused_d = (state_d == ST_PAUSE);
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
    end
  end

  assign step   = step_q;
  assign dir    = dir_q;
  assign speed  = speed_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_marquee_tick_ctrl.sv
// tb_marquee_tick_ctrl: directed stimulus with a cycle model feeding an
// expected-output queue, plus timing checks on observed step pulses.
module tb_marquee_tick_ctrl;

  localparam int DEB  = 4;
  localparam int BASE = 16;
  // Press takes effect on outputs this many edges after btn is set
  localparam int LAT  = DEB + 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       step;
  logic       dir;
  logic [1:0] speed;
  logic       paused;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int last_step = -1;
  int prev_step = -1;
  int nsteps = 0;

  int eff0_q[$];
  int eff1_q[$];
  int eff2_q[$];
  int eff3_q[$];
  logic [4:0] exp_q[$];

  int         m_cnt = 0;
  logic [1:0] m_speed = 2'd0;
  logic       m_dir = 1'b0;
  logic       m_paused = 1'b0;
  logic       m_step = 1'b0;

  marquee_tick_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .BASE_DIV    (BASE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .step  (step),
    .dir   (dir),
    .speed (speed),
    .paused(paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Hold button b high for 'hold' cycles; schedule its model effect
  task automatic press(input int b, input int hold);
    int t0;
    t0 = cyc;
    btn[b] = 1'b1;
    case (b)
      0: eff0_q.push_back(t0 + LAT);
      1: eff1_q.push_back(t0 + LAT);
      2: eff2_q.push_back(t0 + LAT);
      default: eff3_q.push_back(t0 + LAT);
    endcase
    goto(t0 + hold);
    btn[b] = 1'b0;
  endtask

  // Cycle model and output scoreboard, evaluated each falling edge
  initial begin
    logic [3:0] mp;
    logic       ss;
    logic [4:0] e;
    logic [4:0] obs;
    int         per;
    int         tmp;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
        m_cnt = 0;
        m_speed = 2'd0;
        m_dir = 1'b0;
        m_paused = 1'b0;
        m_step = 1'b0;
        eff0_q.delete();
        eff1_q.delete();
        eff2_q.delete();
        eff3_q.delete();
        exp_q.delete();
        last_step = -1;
        prev_step = -1;
        nsteps = 0;
      end else begin
        cyc++;
        mp = 4'b0000;
        if (eff0_q.size() > 0) if (eff0_q[0] == cyc) begin mp[0] = 1'b1; tmp = eff0_q.pop_front(); end
        if (eff1_q.size() > 0) if (eff1_q[0] == cyc) begin mp[1] = 1'b1; tmp = eff1_q.pop_front(); end
        if (eff2_q.size() > 0) if (eff2_q[0] == cyc) begin mp[2] = 1'b1; tmp = eff2_q.pop_front(); end
        if (eff3_q.size() > 0) if (eff3_q[0] == cyc) begin mp[3] = 1'b1; tmp = eff3_q.pop_front(); end

        m_step = 1'b0;
        ss = mp[3] & m_paused;
        if (mp[1]) m_dir = ~m_dir;
        per = BASE >> m_speed;
        if (mp[0]) begin
          m_speed = m_speed + 2'd1;
          m_cnt = 0;
        end else if (!m_paused) begin
          if (m_cnt == per - 1) begin
            m_cnt = 0;
            m_step = 1'b1;
          end else begin
            m_cnt++;
          end
        end
        if (mp[2]) m_paused = ~m_paused;
        if (ss) m_step = 1'b1;

        exp_q.push_back({m_step, m_dir, m_speed, m_paused});
        obs = {step, dir, speed, paused};
        e = exp_q.pop_front();
        chk("outputs{step,dir,speed,paused}", int'(obs), int'(e));

        if (step === 1'b1) begin
          prev_step = last_step;
          last_step = cyc;
          nsteps++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    int n0;
    btn = 4'b0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_speed", int'(speed), 0);
    chk("rst_paused", int'(paused), 0);
    rst = 1'b0;

    // Idle run at speed 0
    goto(17);
    chk("first_step", last_step, 16);
    chk("first_step_count", nsteps, 1);
    goto(49);
    chk("idle_last", last_step, 48);
    chk("idle_prev", prev_step, 32);

    // Short glitch on speed button, then real presses through the wrap
    goto(50);
    btn[0] = 1'b1;
    goto(53);
    btn[0] = 1'b0;
    goto(70);
    chk("glitch_speed", int'(speed), 0);
    press(0, 10);
    goto(95);
    chk("spd1", int'(speed), 1);
    chk("spd1_last", last_step, 94);
    chk("spd1_prev", prev_step, 86);
    goto(100);
    press(0, 10);
    goto(121);
    chk("spd2", int'(speed), 2);
    chk("spd2_last", last_step, 120);
    chk("spd2_prev", prev_step, 116);
    goto(130);
    press(0, 10);
    goto(150);
    chk("spd3", int'(speed), 3);
    chk("spd3_last", last_step, 150);
    chk("spd3_prev", prev_step, 148);
    goto(160);
    press(0, 10);
    goto(185);
    chk("spd_wrap", int'(speed), 0);
    chk("wrap_last", last_step, 184);
    chk("wrap_suppressed_prev", prev_step, 166);

    // Pause at cnt=5, hold 200 cycles, single step, resume
    goto(214);
    press(2, 10);
    chk("pause_on", int'(paused), 1);
    chk("pause_last", last_step, 216);
    goto(422);
    chk("pause_hold_last", last_step, 216);
    chk("pause_hold_flag", int'(paused), 1);
    n0 = nsteps;
    goto(430);
    press(3, 10);
    chk("single_step_at", last_step, 438);
    chk("single_step_count", nsteps, n0 + 1);
    chk("single_step_paused", int'(paused), 1);
    goto(460);
    press(2, 10);
    goto(479);
    chk("resume_flag", int'(paused), 0);
    chk("resume_step", last_step, 478);
    goto(495);
    chk("resume_period_last", last_step, 494);
    chk("resume_period_prev", prev_step, 478);

    // Single step ignored in RUN; direction toggles
    goto(500);
    press(3, 10);
    goto(511);
    chk("run_step_ign_last", last_step, 510);
    chk("run_step_ign_prev", prev_step, 494);
    goto(520);
    press(1, 10);
    chk("dir_1", int'(dir), 1);
    goto(540);
    press(1, 10);
    goto(559);
    chk("dir_0", int'(dir), 0);
    chk("dir_cadence_last", last_step, 558);
    chk("dir_cadence_prev", prev_step, 542);

    // Speed press landing on the terminal count
    goto(582);
    press(0, 10);
    chk("tc_speed", int'(speed), 1);
    chk("tc_no_step", last_step, 574);
    goto(599);
    chk("tc_next_step", last_step, 598);

    // Build speed=2, dir=1, paused=1 then reset asynchronously mid-debounce
    goto(610);
    press(0, 10);
    goto(630);
    press(1, 10);
    goto(650);
    press(2, 10);
    goto(670);
    chk("pre_rst_speed", int'(speed), 2);
    chk("pre_rst_dir", int'(dir), 1);
    chk("pre_rst_paused", int'(paused), 1);
    chk("pause_on_tc_step", last_step, 658);
    goto(680);
    btn[0] = 1'b1;
    goto(682);
    rst = 1'b1;
    #1;
    chk("async_rst_step", int'(step), 0);
    chk("async_rst_dir", int'(dir), 0);
    chk("async_rst_speed", int'(speed), 0);
    chk("async_rst_paused", int'(paused), 0);
    btn[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    goto(17);
    chk("post_rst_first", last_step, 16);
    chk("post_rst_count", nsteps, 1);
    chk("post_rst_speed", int'(speed), 0);
    goto(40);
    chk("post_rst_last", last_step, 32);
    chk("effects_drained", eff0_q.size() + eff1_q.size() + eff2_q.size() + eff3_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
